// File: rtl/lfsr_keystream_gen_if.sv
// Seed-in and key-out valid/ready channels of lfsr_keystream_gen.
interface lfsr_keystream_gen_if #(
  parameter int KEY_WIDTH = 256,
  parameter int TAG_WIDTH = 8
);
  logic                 seed_valid;
  logic                 seed_ready;
  logic [KEY_WIDTH-1:0] seed_data;
  logic                 key_valid;
  logic                 key_ready;
  logic [KEY_WIDTH-1:0] key_out;
  logic [TAG_WIDTH-1:0] tag_out;

  modport master (
    output seed_valid, seed_data, key_ready,
    input  seed_ready, key_valid, key_out, tag_out
  );

  modport slave (
    input  seed_valid, seed_data, key_ready,
    output seed_ready, key_valid, key_out, tag_out
  );
endinterface

// File: rtl/lfsr_keystream_gen.sv
// Multi-lane Fibonacci LFSR keystream: key+tag every STEPS_PER_KEY cycles, held until taken; seed refused while running.
// KEYGEN_HEALTH_EN adds a repeated-key detector driving health_err.
module lfsr_keystream_gen #(
  parameter int NUM_LANES      = 4,
  parameter int LANE_WIDTH     = 64,
  parameter int AUTH_TAG_WIDTH = 8,
  parameter int STEPS_PER_KEY  = 64
) (
  input  logic                 clk,
  input  logic                 resetN,
  lfsr_keystream_gen_if.slave  bus,
  output logic                 busy,
  output logic                 seed_fix,
  output logic                 health_err
);
  localparam int KEY_WIDTH  = NUM_LANES * LANE_WIDTH;
  localparam int TAG_STRIDE = KEY_WIDTH / AUTH_TAG_WIDTH;
  localparam int CNT_W      = $clog2(STEPS_PER_KEY + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS_PER_KEY - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                    state, state_nxt;
  logic [KEY_WIDTH-1:0]      lanes, lanes_step, seed_fixed;
  logic [CNT_W-1:0]          cnt;
  logic [KEY_WIDTH-1:0]      key_q;
  logic [AUTH_TAG_WIDTH-1:0] tag_q;
  logic                      key_vld_q;
  logic                      seed_fix_q;
  logic                      zero_any;
  logic                      seed_xfer;
  logic                      last_step;

  function automatic logic [KEY_WIDTH-1:0] step_all(input logic [KEY_WIDTH-1:0] s);
    logic [KEY_WIDTH-1:0]  n;
    logic [LANE_WIDTH-1:0] l;
    n = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      l = s[i*LANE_WIDTH +: LANE_WIDTH];
      n[i*LANE_WIDTH +: LANE_WIDTH] = {l[LANE_WIDTH-2:0],
        l[LANE_WIDTH-1] ^ l[LANE_WIDTH-3] ^ l[LANE_WIDTH-4] ^ l[LANE_WIDTH-5]};
    end
    return n;
  endfunction

  function automatic logic [AUTH_TAG_WIDTH-1:0] tag_of(input logic [KEY_WIDTH-1:0] k);
    logic [AUTH_TAG_WIDTH-1:0] t;
    t = '0;
    for (int i = 0; i < AUTH_TAG_WIDTH; i++)
      t[i] = k[(i * TAG_STRIDE + 10) % KEY_WIDTH];
    return t;
  endfunction

  // An all-zero lane would lock up forever, so it is forced to 1.
  always_comb begin
    seed_fixed = bus.seed_data;
    zero_any   = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (bus.seed_data[i*LANE_WIDTH +: LANE_WIDTH] == '0) begin
        seed_fixed[i*LANE_WIDTH] = 1'b1;
        zero_any                 = 1'b1;
      end
    end
  end

  assign lanes_step = step_all(lanes);
  assign seed_xfer  = bus.seed_valid && (state != RUN);
  assign last_step  = (cnt == LAST_STEP);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (seed_xfer) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = HOLD;
      HOLD:    if (seed_xfer || bus.key_ready) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lanes      <= '0;
      cnt        <= '0;
      key_q      <= '0;
      tag_q      <= '0;
      key_vld_q  <= 1'b0;
      seed_fix_q <= 1'b0;
    end else if (seed_xfer) begin
      lanes      <= seed_fixed;
      cnt        <= '0;
      key_vld_q  <= 1'b0;
      seed_fix_q <= zero_any;
    end else if (state == RUN) begin
      lanes <= lanes_step;
      cnt   <= cnt + 1'b1;
      if (last_step) begin
        key_q     <= lanes_step;
        tag_q     <= tag_of(lanes_step);
        key_vld_q <= 1'b1;
      end
    end else if (state == HOLD && bus.key_ready) begin
      key_vld_q <= 1'b0;
      cnt       <= '0;
    end
  end

`ifdef KEYGEN_HEALTH_EN
  logic [KEY_WIDTH-1:0] prev_key;
  logic                 have_prev;
  logic                 health_q;

  // First key after a seed has nothing to compare against.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prev_key  <= '0;
      have_prev <= 1'b0;
      health_q  <= 1'b0;
    end else if (seed_xfer) begin
      have_prev <= 1'b0;
      if (!zero_any) health_q <= 1'b0;
    end else if (state == RUN && last_step) begin
      prev_key  <= lanes_step;
      have_prev <= 1'b1;
      if (have_prev && (prev_key == lanes_step)) health_q <= 1'b1;
    end
  end

  assign health_err = health_q;
`else
  assign health_err = 1'b0;
`endif

  assign bus.seed_ready = (state != RUN);
  assign bus.key_valid  = key_vld_q;
  assign bus.key_out    = key_q;
  assign bus.tag_out    = tag_q;
  assign busy           = (state == RUN);
  assign seed_fix       = seed_fix_q;
endmodule

// File: tb/tb_lfsr_keystream_gen.sv
// Bench for lfsr_keystream_gen: three configurations, scoreboard of expected key/tag pairs.
module tb_lfsr_keystream_gen;
  typedef logic [255:0] wv_t;
  typedef struct {
    wv_t key;
    wv_t tag;
  } exp_t;

`ifdef KEYGEN_HEALTH_EN
  localparam logic HEXP = 1'b1;
`else
  localparam logic HEXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  logic busy_a, busy_b, busy_c;
  logic fix_a, fix_b, fix_c;
  logic herr_a, herr_b, herr_c;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  lfsr_keystream_gen_if #(.KEY_WIDTH(8),   .TAG_WIDTH(8)) ia();
  lfsr_keystream_gen_if #(.KEY_WIDTH(256), .TAG_WIDTH(8)) ib();
  lfsr_keystream_gen_if #(.KEY_WIDTH(8),   .TAG_WIDTH(8)) ic();

  lfsr_keystream_gen #(.NUM_LANES(1), .LANE_WIDTH(8), .AUTH_TAG_WIDTH(8), .STEPS_PER_KEY(1)) dut_a (
    .clk(clk), .resetN(rst_a), .bus(ia), .busy(busy_a), .seed_fix(fix_a), .health_err(herr_a));
  lfsr_keystream_gen dut_b (
    .clk(clk), .resetN(rst_b), .bus(ib), .busy(busy_b), .seed_fix(fix_b), .health_err(herr_b));
  lfsr_keystream_gen #(.NUM_LANES(1), .LANE_WIDTH(8), .AUTH_TAG_WIDTH(8), .STEPS_PER_KEY(255)) dut_c (
    .clk(clk), .resetN(rst_c), .bus(ic), .busy(busy_c), .seed_fix(fix_c), .health_err(herr_c));

  task automatic chk(input string tag, input wv_t got, input wv_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: Fibonacci taps W-1, W-3, W-4, W-5 shifted into bit 0.
  function automatic wv_t m_step(input wv_t s, input int nl, input int w);
    wv_t n;
    n = '0;
    for (int l = 0; l < nl; l++) begin
      n[l*w] = s[l*w+w-1] ^ s[l*w+w-3] ^ s[l*w+w-4] ^ s[l*w+w-5];
      for (int b = 1; b < w; b++) n[l*w+b] = s[l*w+b-1];
    end
    return n;
  endfunction

  function automatic wv_t m_tag(input wv_t k, input int kw, input int tw);
    wv_t t;
    t = '0;
    for (int i = 0; i < tw; i++) t[i] = k[(i*(kw/tw)+10) % kw];
    return t;
  endfunction

  task automatic pop_chk(input string tag, input wv_t key, input wv_t tg);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_key"}, key, e.key);
      chk({tag, "_tag"}, tg, e.tag);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    wv_t s, k;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    ia.seed_valid = 1'b0; ia.seed_data = '0; ia.key_ready = 1'b0;
    ib.seed_valid = 1'b0; ib.seed_data = '0; ib.key_ready = 1'b0;
    ic.seed_valid = 1'b0; ic.seed_data = '0; ic.key_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_key_valid", ib.key_valid, 0);
    chk("rst_key_out",   ib.key_out, 0);
    chk("rst_tag_out",   ib.tag_out, 0);
    chk("rst_busy",      busy_b, 0);
    chk("rst_flags",     {fix_b, herr_b}, 0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(negedge clk);
    chk("rst_seed_ready", ib.seed_ready, 1);

    // Small config, continuous consumption.
    sbq.push_back('{256'h02, 256'h80});
    sbq.push_back('{256'h04, 256'h01});
    sbq.push_back('{256'h08, 256'h02});
    sbq.push_back('{256'h11, 256'h44});
    ia.key_ready = 1'b1; ia.seed_data = 8'h01; ia.seed_valid = 1'b1;
    @(posedge clk); #1 ia.seed_valid = 1'b0;
    cyc = 0;
    while (sbq.size() > 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (ia.key_valid && ia.key_ready) pop_chk("a_stream", ia.key_out, ia.tag_out);
    end
    chk("a_stream_drained", sbq.size(), 0);
    sbq.delete();

    // Zero seed while a key is pending: key dropped, lane fixed.
    ia.key_ready = 1'b0;
    cyc = 0;
    while (!ia.key_valid && cyc < 10) begin @(negedge clk); cyc++; end
    sbq.push_back('{256'h02, 256'h80});
    ia.seed_data = 8'h00; ia.seed_valid = 1'b1;
    @(posedge clk); #1 ia.seed_valid = 1'b0;
    chk("a_seed_fix_set", fix_a, 1);
    chk("a_drop_valid", ia.key_valid, 0);
    cyc = 0;
    while (!ia.key_valid && cyc < 10) begin @(negedge clk); cyc++; end
    pop_chk("a_fixed", ia.key_out, ia.tag_out);
    @(negedge clk);
    ia.seed_data = 8'h01; ia.seed_valid = 1'b1;
    @(posedge clk); #1 ia.seed_valid = 1'b0;
    chk("a_seed_fix_clr", fix_a, 0);

    // Default config: latency, hold stability, busy.
    s = {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
         64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000};
    k = s;
    for (int i = 0; i < 64; i++) k = m_step(k, 4, 64);
    sbq.push_back('{k, m_tag(k, 256, 8)});
    @(negedge clk);
    ib.seed_data = s; ib.seed_valid = 1'b1;
    @(posedge clk); #1 ib.seed_valid = 1'b0;
    chk("b_busy_run", busy_b, 1);
    chk("b_seed_ready_run", ib.seed_ready, 0);
    cyc = 0;
    while (!ib.key_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("b_latency", cyc, 64);
    chk("b_busy_hold", busy_b, 0);
    repeat (20) begin
      @(negedge clk);
      if (sbq.size() > 0) chk("b_hold_key", ib.key_out, sbq[0].key);
      chk("b_hold_valid", ib.key_valid, 1);
    end
    if (sbq.size() > 0) chk("b_hold_tag", ib.tag_out, sbq[0].tag);

    // Seed and key_ready on the same edge.
    s = {64'h1, 64'h2, 64'h3, 64'hdead_beef_0000_0000};
    ib.seed_data = s; ib.seed_valid = 1'b1; ib.key_ready = 1'b1;
    if (ib.key_valid && ib.key_ready) pop_chk("b_first", ib.key_out, ib.tag_out);
    k = s;
    for (int i = 0; i < 64; i++) k = m_step(k, 4, 64);
    sbq.push_back('{k, m_tag(k, 256, 8)});
    @(posedge clk); #1 ib.seed_valid = 1'b0; ib.key_ready = 1'b0;
    chk("b_after_both_valid", ib.key_valid, 0);
    cyc = 0;
    while (!ib.key_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("b_latency2", cyc, 64);
    @(negedge clk);
    ib.key_ready = 1'b1;
    if (ib.key_valid && ib.key_ready) pop_chk("b_second", ib.key_out, ib.tag_out);
    @(posedge clk); #1 ib.key_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("b_busy_before_rst", busy_b, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("b_arst_valid", ib.key_valid, 0);
    chk("b_arst_key",   ib.key_out, 0);
    chk("b_arst_tag",   ib.tag_out, 0);
    chk("b_arst_busy",  busy_b, 0);
    @(negedge clk); rst_b = 1'b1;
    chk("b_sb_drained", sbq.size(), 0);
    sbq.delete();

    // Period-255 lane: repeated key detection.
    sbq.push_back('{256'h5A, 256'h96});
    sbq.push_back('{256'h5A, 256'h96});
    ic.seed_data = 8'h5A; ic.seed_valid = 1'b1;
    @(posedge clk); #1 ic.seed_valid = 1'b0;
    cyc = 0;
    while (!ic.key_valid && cyc < 300) begin @(posedge clk); #1; cyc++; end
    chk("c_latency", cyc, 255);
    @(negedge clk);
    chk("c_health_k1", herr_c, 0);
    ic.key_ready = 1'b1;
    if (ic.key_valid) pop_chk("c_k1", ic.key_out, ic.tag_out);
    @(posedge clk); #1 ic.key_ready = 1'b0;
    cyc = 0;
    while (!ic.key_valid && cyc < 300) begin @(negedge clk); cyc++; end
    chk("c_health_k2", herr_c, HEXP);
    ic.key_ready = 1'b1; ic.seed_data = 8'h5A; ic.seed_valid = 1'b1;
    if (ic.key_valid) pop_chk("c_k2", ic.key_out, ic.tag_out);
    @(posedge clk); #1 ic.key_ready = 1'b0; ic.seed_valid = 1'b0;
    chk("c_health_clr", herr_c, 0);
    chk("c_seed_fix", fix_c, 0);
    chk("c_sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
